pc_ctrl_alu_core: RTL and testbench
===================================

PC_CTRL_ALU_CORE -- requirements
Module: pc_ctrl_alu_core

Interface
REQ-001 Parameter: DW, 32, datapath and address width in bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-low reset; sampled only on the rising clk edge.
REQ-005 instr  input  DW  current instruction (RV32I encoding) fetched at pc.
REQ-006 rd1  input  DW  register-file value addressed by instr[19:15].
REQ-007 rd2  input  DW  register-file value addressed by instr[24:20].
REQ-008 pc  output  DW  registered program counter.
REQ-009 imm_op  output  DW  sign-extended immediate of instr.
REQ-010 alu_out  output  DW  ALU result, write-back data.
REQ-011 eq  output  1  high when ALU operand 1 equals ALU operand 2.
REQ-012 reg_write  output  1  register-file write enable for instr[11:7].
REQ-013 pc_src  output  1  branch taken; selects pc+imm_op as next pc.

Function
REQ-014 Decoding, immediate, ALU, eq and pc_src SHALL be combinational from instr, rd1, rd2; only pc is registered.
REQ-015 Supported: ADDI (opcode 0010011, f3 000); ADD/SUB (0110011, f3 000, f7 0000000/0100000); AND (f3 111), OR (f3 110), SLT (f3 010) under 0110011 with f7 0; BEQ (1100011, f3 000); BNE (1100011, f3 001).
REQ-016 ALU controls: ADD 000, SUB 001, AND 010, OR 011, SLT 101; SLT yields 1 if op1 < op2 signed, else 0.
REQ-017 Operand 1 SHALL be rd1; operand 2 SHALL be imm_op for ADDI, rd2 otherwise.
REQ-018 Arithmetic SHALL be modulo 2^DW; overflow and carry ignored, no flags beyond eq.
REQ-019 Immediate formats: I = sign-extend instr[31:20]; B = sign-extend {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; S, U, J formats decoded per RV32I (for future use); any other opcode yields imm_op 0.
REQ-020 reg_write SHALL be 1 for ADDI and R-type ops, 0 for branches and unsupported opcodes.
REQ-021 Branches SHALL use SUB with operand 2 = rd2; pc_src = eq for BEQ, !eq for BNE, 0 for all other instructions.
REQ-022 eq SHALL be computed for every instruction from the selected operands.
REQ-023 Next pc SHALL be pc + imm_op when pc_src=1, else pc + 4; update every rising edge with rst high; wraps modulo 2^DW.
REQ-024 Unsupported opcodes, funct3 or funct7 SHALL act as NOP: reg_write 0, pc_src 0, ALU control ADD, pc advances by 4.

Reset
REQ-025 rst low at a rising edge SHALL set pc to 0, overriding any pending branch.
REQ-026 Combinational outputs SHALL follow instr/rd1/rd2 during reset; reg_write is not gated by reset.
REQ-027 Reset asserted mid-program SHALL take effect on the next edge with no intermediate pc value.

Verification
REQ-028 rst low one edge, instr=0x00500093, rd1=0 -> pc=0; then imm_op=5, alu_out=5, reg_write=1, pc_src=0; next edge pc=4.
REQ-029 instr=0x002081B3 (ADD), rd1=7, rd2=0xFFFFFFFF -> alu_out=6, reg_write=1; instr=0x402081B3 (SUB), rd1=3, rd2=5 -> alu_out=0xFFFFFFFE.
REQ-030 pc=8, instr=0xFE009EE3 (BNE x1,x0,-4), rd1=3, rd2=0 -> imm_op=0xFFFFFFFC, eq=0, pc_src=1, reg_write=0, next pc=4.
REQ-031 Same BNE with rd1=0, rd2=0 -> eq=1, pc_src=0, next pc=12; BEQ variant 0xFE008EE3 with equal operands -> pc_src=1, next pc=4.
REQ-032 Branch taken with rst low at the same edge -> pc=0; instr=0xFFFFFFFF -> reg_write=0, pc_src=0, pc+4.
REQ-033 pc=0xFFFFFFFC, NOP -> next pc=0 (wrap).

Source files
------------

// File: rtl/pc_ctrl_alu_core.sv
// Single-cycle RV32I subset core slice: decode, immediate generation, ALU and
// branch resolution are combinational; only the program counter is registered.
module pc_ctrl_alu_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] imm_op,
  output logic [DW-1:0] alu_out,
  output logic          eq,
  output logic          reg_write,
  output logic          pc_src
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [2:0]    alu_ctrl;
  logic          use_imm;
  logic          is_beq;
  logic          is_bne;
  logic [31:0]   imm32;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [DW-1:0] and_v;
  logic [DW-1:0] or_v;
  logic [DW-1:0] pc_reg;
  logic [DW-1:0] pc_next;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Anything not fully decoded below falls through as a NOP with ADD control.
  always_comb begin
    alu_ctrl  = ALU_ADD;
    reg_write = 1'b0;
    use_imm   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          reg_write = 1'b1;
          use_imm   = 1'b1;
        end
      end
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  begin alu_ctrl = ALU_ADD; reg_write = 1'b1; end
            3'b111:  begin alu_ctrl = ALU_AND; reg_write = 1'b1; end
            3'b110:  begin alu_ctrl = ALU_OR;  reg_write = 1'b1; end
            3'b010:  begin alu_ctrl = ALU_SLT; reg_write = 1'b1; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alu_ctrl  = ALU_SUB;
          reg_write = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000) begin
          alu_ctrl = ALU_SUB;
          is_beq   = 1'b1;
        end else if (funct3 == 3'b001) begin
          alu_ctrl = ALU_SUB;
          is_bne   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imm32 = 32'd0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm32 = {instr[31:12], 12'd0};
      OP_JAL:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:   imm32 = 32'd0;
    endcase
  end

  assign imm_op = DW'($signed(imm32));
  assign op1    = rd1;
  assign op2    = use_imm ? imm_op : rd2;

  for (genvar gi = 0; gi < DW; gi++) begin : g_logic
    assign and_v[gi] = op1[gi] & op2[gi];
    assign or_v[gi]  = op1[gi] | op2[gi];
  end

  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_out = op1 + op2;
      ALU_SUB: alu_out = op1 - op2;
      ALU_AND: alu_out = and_v;
      ALU_OR:  alu_out = or_v;
      ALU_SLT: alu_out = DW'($signed(op1) < $signed(op2));
      default: alu_out = op1 + op2;
    endcase
  end

  assign eq      = (op1 == op2);
  assign pc_src  = (is_beq & eq) | (is_bne & ~eq);
  assign pc_next = pc_reg + (pc_src ? imm_op : DW'(4));

  // Reset wins over any branch resolved in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) pc_reg <= '0;
    else      pc_reg <= pc_next;
  end

  assign pc = pc_reg;

endmodule

// File: tb/tb_pc_ctrl_alu_core.sv
// Directed plus randomized checks of pc_ctrl_alu_core against a mnemonic-level
// reference model of the RV32I subset.
module tb_pc_ctrl_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rd1, rd2;
  logic [31:0] pc, imm_op, alu_out;
  logic        eq, reg_write, pc_src;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc;
  logic [31:0] m_imm, m_alu;
  logic        m_eq, m_rw, m_ps;

  pc_ctrl_alu_core #(.DW(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .rd1(rd1), .rd2(rd2),
    .pc(pc), .imm_op(imm_op), .alu_out(alu_out), .eq(eq),
    .reg_write(reg_write), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] imm, output logic [31:0] alu,
                       output logic e, output logic rw, output logic ps);
    int    op = int'(i[6:0]);
    int    f3 = int'(i[14:12]);
    int    f7 = int'(i[31:25]);
    string m;
    logic [31:0] o2;
    case (op)
      'h13, 'h03, 'h67: imm = sext(int'(i[31:20]), 12);
      'h23: imm = sext(int'(i[31:25]) * 32 + int'(i[11:7]), 12);
      'h63: imm = sext(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                       + int'(i[11:8]) * 2, 13);
      'h37, 'h17: imm = i & 32'hFFFFF000;
      'h6F: imm = sext(int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                       + int'(i[30:21]) * 2, 21);
      default: imm = 32'd0;
    endcase
    m = "nop";
    if (op == 'h13 && f3 == 0) m = "addi";
    else if (op == 'h33 && f7 == 0 && f3 == 0) m = "add";
    else if (op == 'h33 && f7 == 'h20 && f3 == 0) m = "sub";
    else if (op == 'h33 && f7 == 0 && f3 == 7) m = "and";
    else if (op == 'h33 && f7 == 0 && f3 == 6) m = "or";
    else if (op == 'h33 && f7 == 0 && f3 == 2) m = "slt";
    else if (op == 'h63 && f3 == 0) m = "beq";
    else if (op == 'h63 && f3 == 1) m = "bne";
    o2 = (m == "addi") ? imm : b;
    case (m)
      "sub", "beq", "bne": alu = a - o2;
      "and": alu = a & o2;
      "or":  alu = a | o2;
      "slt": alu = (int'(a) < int'(o2)) ? 32'd1 : 32'd0;
      default: alu = a + o2;
    endcase
    e  = (a == o2);
    rw = (m == "addi" || m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt");
    ps = (m == "beq" && e) || (m == "bne" && !e);
  endtask

  // Drive inputs just after an edge, then check the combinational outputs.
  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i; rd1 = a; rd2 = b;
    #1;
    model(i, a, b, m_imm, m_alu, m_eq, m_rw, m_ps);
    check("imm_op", imm_op, m_imm);
    check("alu_out", alu_out, m_alu);
    check("eq", {31'd0, eq}, {31'd0, m_eq});
    check("reg_write", {31'd0, reg_write}, {31'd0, m_rw});
    check("pc_src", {31'd0, pc_src}, {31'd0, m_ps});
  endtask

  task automatic cyc();
    exp_pc = !rst ? 32'd0 : (m_ps ? exp_pc + m_imm : exp_pc + 32'd4);
    @(posedge clk);
    #1;
    check("pc", pc, exp_pc);
    $display("txn instr=%h rd1=%h rd2=%h rst=%b -> alu=%h imm=%h eq=%b rw=%b ps=%b pc=%h",
             instr, rd1, rd2, rst, alu_out, imm_op, eq, reg_write, pc_src, pc);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    apply(32'hFFFFFFFF, 32'd0, 32'd0);
    cyc();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [4:0]  rs1 = r[19:15];
    logic [4:0]  rs2 = r[24:20];
    logic [4:0]  rdx = r[11:7];
    logic [6:0]  uop[5] = '{7'h23, 7'h37, 7'h17, 7'h6F, 7'h03};
    case ($urandom_range(0, 10))
      0: return {r[31:20], rs1, 3'b000, rdx, 7'h13};
      1: return {7'h00, rs2, rs1, 3'b000, rdx, 7'h33};
      2: return {7'h20, rs2, rs1, 3'b000, rdx, 7'h33};
      3: return {7'h00, rs2, rs1, 3'b111, rdx, 7'h33};
      4: return {7'h00, rs2, rs1, 3'b110, rdx, 7'h33};
      5: return {7'h00, rs2, rs1, 3'b010, rdx, 7'h33};
      6: return {r[31:25], rs2, rs1, 3'b000, r[11:7], 7'h63};
      7: return {r[31:25], rs2, rs1, 3'b001, r[11:7], 7'h63};
      8: return {r[31:7], uop[$urandom_range(0, 4)]};
      9: return {r[31:7], 7'h33};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    rst = 1'b0; instr = '0; rd1 = '0; rd2 = '0; exp_pc = '0;
    m_imm = '0; m_alu = '0; m_eq = 1'b0; m_rw = 1'b0; m_ps = 1'b0;
    @(negedge clk);

    // Reset edge with ADDI presented; outputs follow instr during reset.
    apply(32'h00500093, 32'd0, 32'd0);
    check("r28_imm", imm_op, 32'd5);
    check("r28_alu", alu_out, 32'd5);
    check("r28_rw", {31'd0, reg_write}, 32'd1);
    check("r28_ps", {31'd0, pc_src}, 32'd0);
    cyc();
    check("r28_pc_rst", pc, 32'd0);
    rst = 1'b1;
    cyc();
    check("r28_pc4", pc, 32'd4);

    apply(32'h002081B3, 32'd7, 32'hFFFFFFFF);
    check("r29_add", alu_out, 32'd6);
    check("r29_rw", {31'd0, reg_write}, 32'd1);
    cyc();
    apply(32'h402081B3, 32'd3, 32'd5);
    check("r29_sub", alu_out, 32'hFFFFFFFE);
    cyc();

    do_reset();
    apply(32'hFFFFFFFF, 32'd0, 32'd0); cyc();
    apply(32'hFFFFFFFF, 32'd0, 32'd0); cyc();
    check("r30_pc8", pc, 32'd8);
    apply(32'hFE009EE3, 32'd3, 32'd0);
    check("r30_imm", imm_op, 32'hFFFFFFFC);
    check("r30_eq", {31'd0, eq}, 32'd0);
    check("r30_ps", {31'd0, pc_src}, 32'd1);
    check("r30_rw", {31'd0, reg_write}, 32'd0);
    cyc();
    check("r30_pc", pc, 32'd4);

    apply(32'hFFFFFFFF, 32'd0, 32'd0); cyc();
    apply(32'hFE009EE3, 32'd0, 32'd0);
    check("r31_eq", {31'd0, eq}, 32'd1);
    check("r31_ps", {31'd0, pc_src}, 32'd0);
    cyc();
    check("r31_pc12", pc, 32'd12);

    do_reset();
    apply(32'hFFFFFFFF, 32'd0, 32'd0); cyc();
    apply(32'hFFFFFFFF, 32'd0, 32'd0); cyc();
    apply(32'hFE008EE3, 32'd5, 32'd5);
    check("r31_beq_ps", {31'd0, pc_src}, 32'd1);
    cyc();
    check("r31_beq_pc", pc, 32'd4);

    // Taken branch coinciding with reset.
    apply(32'hFE008EE3, 32'd9, 32'd9);
    rst = 1'b0;
    cyc();
    check("r32_pc_rst", pc, 32'd0);
    rst = 1'b1;
    apply(32'hFFFFFFFF, 32'd1, 32'd2);
    check("r32_rw", {31'd0, reg_write}, 32'd0);
    check("r32_ps", {31'd0, pc_src}, 32'd0);
    cyc();
    check("r32_pc", pc, 32'd4);

    do_reset();
    apply(32'hFE008EE3, 32'd1, 32'd1); cyc();
    check("r33_pc_top", pc, 32'hFFFFFFFC);
    apply(32'hFFFFFFFF, 32'd0, 32'd0); cyc();
    check("r33_wrap", pc, 32'd0);

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 7) == 0) a = {1'b1, a[30:0]};
      rst = ($urandom_range(0, 19) != 0);
      apply(rand_instr(), a, b);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
